// File: rtl/pred_ctx_seq.sv
// Purpose: per-PE predicate context sequencer; replays stored control words into the predicate RF stage.
// Latency: start sampled at posedge N drives ctx[0] on the outputs right after posedge N; one context per cycle.
// Backpressure: stall inserts a NOP bubble and holds the pointer; optional context check under PRED_CTX_SEQ_CHECK_EN.
module pred_ctx_seq #(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [46:0]       cfg_data,
  input  logic              start,
  input  logic              stall,
  input  logic [CTX_AW-1:0] ctx_last,
  input  logic [7:0]        loop_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CTX_AW-1:0] ctx_ptr,
  output logic [8:0]        control_in_p,
  output logic [8:0]        control_out_p,
  output logic [5:0]        control_put_in_p,
  output logic [5:0]        control_put_out_p,
  output logic [5:0]        control_pred,
  output logic [5:0]        control_send_p,
  output logic [3:0]        control_pe2fu_p,
  output logic              write_back_p
);

  typedef struct packed {
    logic [8:0] in_sel;
    logic [8:0] out_sel;
    logic [5:0] put_in;
    logic [5:0] put_out;
    logic [5:0] pred_rd;
    logic [5:0] send;
    logic [3:0] pe2fu;
    logic       wb;
  } ctx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Context store is deliberately left out of reset so a reset keeps the program.
  ctx_t ctx_mem [CTX_DEPTH];

  state_t            state_q, state_d;
  logic [CTX_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        iter_q, iter_d;
  logic [CTX_AW-1:0] last_q, last_d;
  logic [7:0]        loops_q, loops_d;
  ctx_t              ctrl_q, ctrl_d;

  logic              issue;
  logic [CTX_AW-1:0] issue_idx;
  ctx_t              issue_word;
  logic              mem_we;

  assign mem_we = cfg_we && (state_q == IDLE);

  // Configuration writes, accepted only while idle.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      ctx_mem[cfg_addr] <= ctx_t'(cfg_data);
    end
  end

  // Next-state, pointer/iteration sequencing and selection of the context to issue.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    iter_d    = iter_q;
    last_d    = last_q;
    loops_d   = loops_q;
    issue     = 1'b0;
    issue_idx = '0;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (start) begin
          state_d   = RUN;
          iter_d    = '0;
          last_d    = ctx_last;
          loops_d   = loop_count;
          issue     = 1'b1;
          issue_idx = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (ptr_q < last_q) begin
            ptr_d     = ptr_q + 1'b1;
            issue     = 1'b1;
            issue_idx = ptr_q + 1'b1;
          end else if (iter_q < loops_q) begin
            ptr_d     = '0;
            iter_d    = iter_q + 8'd1;
            issue     = 1'b1;
            issue_idx = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Same-cycle write and start: the freshly written word wins over the stored one.
  always_comb begin
    if (mem_we && (cfg_addr == issue_idx)) begin
      issue_word = ctx_t'(cfg_data);
    end else begin
      issue_word = ctx_mem[issue_idx];
    end
  end

`ifdef PRED_CTX_SEQ_CHECK_EN
  logic err_q, err_d;
  logic word_ok;

  // Only the documented one-hot selects are safe to drive into the RF muxes.
  always_comb begin
    word_ok = (issue_word.in_sel inside {9'h000, 9'h001, 9'h008, 9'h010}) &&
              (issue_word.pe2fu  inside {4'h0, 4'h1, 4'h4, 4'h8});
    ctrl_d  = '0;
    err_d   = err_q;
    if (issue) begin
      if (word_ok) begin
        ctrl_d = issue_word;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Contexts are issued verbatim; a NOP whenever nothing is issued.
  always_comb begin
    ctrl_d = '0;
    if (issue) begin
      ctrl_d = issue_word;
    end
  end

  assign err = 1'b0;
`endif

  // State, counters, sampled program limits and the registered control word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      loops_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      loops_q <= loops_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign ctx_ptr           = ptr_q;
  assign control_in_p      = ctrl_q.in_sel;
  assign control_out_p     = ctrl_q.out_sel;
  assign control_put_in_p  = ctrl_q.put_in;
  assign control_put_out_p = ctrl_q.put_out;
  assign control_pred      = ctrl_q.pred_rd;
  assign control_send_p    = ctrl_q.send;
  assign control_pe2fu_p   = ctrl_q.pe2fu;
  assign write_back_p      = ctrl_q.wb;

endmodule

// File: tb/tb_pred_ctx_seq.sv
module tb_pred_ctx_seq;

  logic        CLK;
  logic        RST_N;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [46:0] cfg_data;
  logic        start;
  logic        stall;
  logic [3:0]  ctx_last;
  logic [7:0]  loop_count;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  ctx_ptr;
  logic [8:0]  control_in_p;
  logic [8:0]  control_out_p;
  logic [5:0]  control_put_in_p;
  logic [5:0]  control_put_out_p;
  logic [5:0]  control_pred;
  logic [5:0]  control_send_p;
  logic [3:0]  control_pe2fu_p;
  logic        write_back_p;

  pred_ctx_seq #(.CTX_DEPTH(16), .CTX_AW(4)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .start             (start),
    .stall             (stall),
    .ctx_last          (ctx_last),
    .loop_count        (loop_count),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .ctx_ptr           (ctx_ptr),
    .control_in_p      (control_in_p),
    .control_out_p     (control_out_p),
    .control_put_in_p  (control_put_in_p),
    .control_put_out_p (control_put_out_p),
    .control_pred      (control_pred),
    .control_send_p    (control_send_p),
    .control_pe2fu_p   (control_pe2fu_p),
    .write_back_p      (write_back_p)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [46:0] ctrl;
  assign ctrl = {control_in_p, control_out_p, control_put_in_p, control_put_out_p,
                 control_pred, control_send_p, control_pe2fu_p, write_back_p};

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [46:0] mk(input logic [8:0] is, input logic [5:0] pi,
                                     input logic [3:0] pf, input logic wb);
    return {is, 9'h1A0 ^ {3'b000, pi}, pi, ~pi, pi ^ 6'h15, 6'(pi + 6'd7), pf, wb};
  endfunction

  logic [46:0] w [0:3];
  logic [46:0] wx;
  logic [46:0] wbad;

  logic [46:0] obs     [0:299];
  logic [3:0]  obs_ptr [0:299];
  int          busy_n;
  int          done_n;

  // Caller is just after a negedge with ctx_last/loop_count set.
  task automatic wr_ctx(input logic [3:0] a, input logic [46:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge CLK);
    cfg_we   = 1'b0;
  endtask

  // Pulses start, then records one sample per cycle; obs[c] is what cycle c drives.
  task automatic run_prog(input int ncyc, input int stall_at, input int inj_at);
    busy_n = 0;
    done_n = 0;
    start  = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        start      = 1'b0;
        cfg_we     = 1'b0;
        ctx_last   = ctx_last ^ 4'hF;
        loop_count = loop_count ^ 8'h5A;
      end
      obs[c]     = ctrl;
      obs_ptr[c] = ctx_ptr;
      if (busy) busy_n++;
      if (done) done_n++;
      stall = (c == stall_at);
      if (c == inj_at) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = wx;
        start    = 1'b1;
      end else if (c == inj_at + 1) begin
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
    stall  = 1'b0;
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  logic [46:0] exp_ls [1:9];

  initial begin
    w[0] = mk(9'h001, 6'd1, 4'h1, 1'b1);
    w[1] = mk(9'h008, 6'd2, 4'h4, 1'b0);
    w[2] = mk(9'h010, 6'd3, 4'h8, 1'b1);
    w[3] = mk(9'h000, 6'd4, 4'h0, 1'b0);
    wx   = mk(9'h010, 6'h2A, 4'h4, 1'b1);
    wbad = mk(9'h003, 6'h11, 4'h1, 1'b1);

    RST_N = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stall = 1'b0; ctx_last = '0; loop_count = '0;

    // Reset then idle
    repeat (3) @(negedge CLK);
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ptr", ctx_ptr, 0);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_eq($sformatf("idle_ctrl%0d", i), ctrl, 0);
      check_eq($sformatf("idle_busy%0d", i), busy, 0);
    end

    // Single pass over four contexts
    for (int i = 0; i < 4; i++) wr_ctx(4'(i), w[i]);
    ctx_last = 4'd3; loop_count = 8'd0;
    run_prog(7, 0, 0);
    for (int c = 1; c <= 7; c++)
      check_eq($sformatf("single_c%0d", c), obs[c], (c <= 4) ? w[c-1] : 47'd0);
    for (int c = 1; c <= 4; c++)
      check_eq($sformatf("single_ptr%0d", c), obs_ptr[c], 4'(c - 1));
    check_eq("single_ptr_idle", obs_ptr[6], 0);
    check_eq("single_busy_n", busy_n, 5);
    check_eq("single_done_n", done_n, 1);

    // Loop with one stall bubble
    exp_ls[1] = w[0]; exp_ls[2] = w[1]; exp_ls[3] = '0; exp_ls[4] = w[0];
    exp_ls[5] = w[1]; exp_ls[6] = w[0]; exp_ls[7] = w[1]; exp_ls[8] = '0; exp_ls[9] = '0;
    ctx_last = 4'd1; loop_count = 8'd2;
    run_prog(9, 2, 0);
    for (int c = 1; c <= 9; c++)
      check_eq($sformatf("loop_c%0d", c), obs[c], exp_ls[c]);
    check_eq("loop_stall_ptr", obs_ptr[3], 1);
    check_eq("loop_busy_n", busy_n, 8);
    check_eq("loop_done_n", done_n, 1);

    // Ignored cfg_we/start during RUN
    ctx_last = 4'd3; loop_count = 8'd0;
    run_prog(8, 0, 2);
    for (int c = 1; c <= 5; c++)
      check_eq($sformatf("ign_c%0d", c), obs[c], (c <= 4) ? w[c-1] : 47'd0);
    check_eq("ign_busy_n", busy_n, 5);
    check_eq("ign_done_n", done_n, 1);
    ctx_last = 4'd0; loop_count = 8'd0;
    run_prog(3, 0, 0);
    check_eq("ign_ctx0_kept", obs[1], w[0]);

    // Write and start in the same idle cycle
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = wx;
    ctx_last = 4'd0; loop_count = 8'd0;
    run_prog(3, 0, 0);
    check_eq("wfirst_c1", obs[1], wx);
    check_eq("wfirst_c2", obs[2], 0);
    wr_ctx(4'd0, w[0]);

    // ctx_last = 0 with three passes
    ctx_last = 4'd0; loop_count = 8'd2;
    run_prog(5, 0, 0);
    for (int c = 1; c <= 4; c++)
      check_eq($sformatf("last0_c%0d", c), obs[c], (c <= 3) ? w[0] : 47'd0);
    check_eq("last0_busy_n", busy_n, 4);

    // loop_count = 255 gives 256 passes
    ctx_last = 4'd0; loop_count = 8'd255;
    run_prog(262, 0, 0);
    check_eq("wrap_c256", obs[256], w[0]);
    check_eq("wrap_c257", obs[257], 0);
    check_eq("wrap_busy_n", busy_n, 257);
    check_eq("wrap_done_n", done_n, 1);

    // Reset in the middle of a run
    ctx_last = 4'd3; loop_count = 8'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check_eq("mid_pre_c2", ctrl, w[1]);
    #2 RST_N = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", ctrl, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    ctx_last = 4'd3; loop_count = 8'd0;
    run_prog(6, 0, 0);
    check_eq("mid_restart_c1", obs[1], w[0]);
    check_eq("mid_restart_c2", obs[2], w[1]);
    check_eq("mid_restart_done_n", done_n, 1);

    // Illegal context in slot 1
    wr_ctx(4'd1, wbad);
    ctx_last = 4'd2; loop_count = 8'd0;
    run_prog(6, 0, 0);
    check_eq("chk_c1", obs[1], w[0]);
`ifdef PRED_CTX_SEQ_CHECK_EN
    check_eq("chk_c2_nop", obs[2], 0);
    check_eq("chk_err", err, 1);
`else
    check_eq("chk_c2_verbatim", obs[2], wbad);
    check_eq("chk_err", err, 0);
`endif
    check_eq("chk_ptr_c2", obs_ptr[2], 1);
    check_eq("chk_c3", obs[3], w[2]);
    RST_N = 1'b0;
    #1;
    check_eq("chk_err_rst", err, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_ctx_seq.md
# pred_ctx_seq

Per-PE predicate context sequencer for the CGRA. Stores a small program of predicate-path control words and replays it, one context per cycle, into the neighbouring predicate register file stage, driving its input-select, write-address, read-address, output-routing and write-back controls. Contexts are loaded through a configuration port while idle. Execution runs for a programmable number of loop iterations, with stall-driven NOP bubbles.

## Interface
- CTX_DEPTH, 16, number of context words (power of two)
- CTX_AW, 4, context address width (log2 CTX_DEPTH)
- CLK  in  1  clock; all state changes on posedge
- RST_N  in  1  asynchronous, active-low reset
- cfg_we  in  1  context write strobe (honoured only in IDLE)
- cfg_addr  in  CTX_AW  context write address
- cfg_data  in  47  context word: [46:38] in_sel, [37:29] out_sel, [28:23] put_in, [22:17] put_out, [16:11] pred_rd, [10:5] send, [4:1] pe2fu, [0] wb
- start  in  1  begin program (honoured only in IDLE)
- stall  in  1  insert NOP bubble, hold pointer
- ctx_last  in  CTX_AW  index of last context in program
- loop_count  in  8  extra passes after the first (0 = one pass)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky illegal-context flag (macro only; else tied 0)
- ctx_ptr  out  CTX_AW  index of context currently driven
- control_in_p, control_out_p  out  9  input mux / output demux selects
- control_put_in_p, control_put_out_p, control_pred, control_send_p  out  6  register-file addresses
- control_pe2fu_p  out  4  FU predicate source select
- write_back_p  out  1  FU result write enable

## Operation
- States: IDLE, RUN, DONE.
- All control outputs are registered. NOP = all control outputs 0. Register-file entry 0 is reserved as a null sink, because a NOP writes 0 to entry 0.
- IDLE: outputs NOP, ctx_ptr=0, busy=0. cfg_we writes cfg_data to ctx[cfg_addr] at posedge. When start=1: go to RUN, ctx_ptr<=0, iteration counter<=0, outputs<=ctx[0]. If cfg_we and start are both high in the same cycle, the write commits first, so ctx[0] reflects the new data when cfg_addr=0.
- RUN, stall=0:
  - If ctx_ptr<ctx_last: ctx_ptr+1, outputs<=ctx[ctx_ptr+1].
  - If ctx_ptr==ctx_last and iter<loop_count: ctx_ptr<=0, iter+1, outputs<=ctx[0].
  - If ctx_ptr==ctx_last and iter==loop_count: go to DONE, outputs<=NOP.
- RUN, stall=1: outputs<=NOP, ctx_ptr and iter held. When stall deasserts, sequencing resumes with ctx[ctx_ptr+1]; no context is replayed or skipped.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- cfg_we and start are ignored in RUN and DONE.
- ctx_last and loop_count are sampled into internal registers on the start cycle. Later changes do not affect a running program.
- The context memory is not reset; RST_N clears only the FSM, counters and output registers.

## Timing
- Reset values: state IDLE, all control outputs 0, ctx_ptr 0, busy 0, done 0, err 0.
- Latency: start sampled at posedge N, so ctx[0] appears after posedge N. The predicate register file consumes it on the following negedge, half a cycle later.
- Throughput: one context per cycle when not stalled.
- Total RUN cycles = (ctx_last+1)×(loop_count+1) + number of stalled cycles.
- Wrap-around: the iteration counter is 8 bits; loop_count=255 gives 256 passes with no overflow.
- ctx_last=0: context 0 is issued on every cycle of the program.
- Reset mid-RUN: at RST_N low, outputs immediately go to NOP and state goes to IDLE. done does not pulse.

## Configuration
- PRED_CTX_SEQ_CHECK_EN defined: when each context is loaded into the output register, in_sel must be one of 0, 9'h001, 9'h008, 9'h010. pe2fu must be one of 0, 4'h1, 4'h4, 4'h8. If either field is illegal, that cycle issues NOP instead, err sets and stays set until reset, and sequencing continues.
- Macro undefined: no checking; contexts are issued verbatim and err is tied to 0.

## Test plan
- Reset then idle: RST_N low for 3 cycles -> all outputs 0, busy=0. Then 5 idle cycles -> outputs remain 0.
- Single pass: load ctx0..3 with distinct put_in values 1..4, ctx_last=3, loop_count=0, pulse start -> control_put_in_p reads 1,2,3,4 on consecutive cycles. Then NOP, done pulses once, busy lasts 5 cycles.
- Loop and stall: ctx_last=1, loop_count=2, stall high on the 3rd RUN cycle -> sequence ctx0,ctx1,NOP,ctx0,ctx1,ctx0,ctx1, then done.
- Ignored commands: issue cfg_we to ctx0 and start during RUN -> ctx0 is unchanged on the next run and the sequence does not restart.
- Reset mid-run: RST_N low at RUN cycle 2 -> outputs 0 at once. After release with start, the program restarts from ctx0 with the contents retained.
- Check macro: load ctx1 with in_sel=9'h003 -> cycle 2 issues NOP, err=1 until reset, and ctx2 follows normally. Without the macro, ctx1 is issued verbatim and err=0.
